// File: rtl/conv_tile_sequencer.sv
// Tile/tap sequencer for a four-DSP 2x2-output-tile convolution datapath.
// Walks every K x K x DEPTH tap of each tile, drains the MAC pipeline, then
// presents the tile with a valid/ready handshake. Tiles are walked row-major.
module conv_tile_sequencer #(
   parameter int IMG_H   = 4,
   parameter int IMG_W   = 4,
   parameter int DEPTH   = 3,
   parameter int K       = 3,
   parameter int MAC_LAT = 1,
   parameter int IW      = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [IW-1:0] frow,
   output logic [IW-1:0] fcol,
   output logic [IW-1:0] fdep,
   output logic [IW-1:0] irow,
   output logic [IW-1:0] icol,
   output logic [IW-1:0] idep,
   output logic          mac_ce,
   output logic          mac_load,
   output logic          op_zero,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [IW-1:0] tile_row,
   output logic [IW-1:0] tile_col
);

   localparam int OH = IMG_H - K + 1;
   localparam int OW = IMG_W - K + 1;

   localparam logic [IW-1:0] ONE     = IW'(1);
   localparam logic [IW-1:0] TWO     = IW'(2);
   localparam logic [IW-1:0] K_LAST  = IW'(K - 1);
   localparam logic [IW-1:0] D_LAST  = IW'(DEPTH - 1);
   localparam logic [IW-1:0] TR_LAST = IW'(OH - 2);
   localparam logic [IW-1:0] TC_LAST = IW'(OW - 2);
   localparam logic [2:0]    DR_LAST = 3'(MAC_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_HOLD,
      S_DONE
   } state_t;

   state_t     state;
   logic [2:0] drain_cnt;

   // Sequencer FSM; every output is registered and updated alongside the state.
   // irow/icol are kept incrementally equal to tile origin + frow/fcol.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         frow      <= '0;
         fcol      <= '0;
         fdep      <= '0;
         irow      <= '0;
         icol      <= '0;
         idep      <= '0;
         mac_ce    <= 1'b0;
         mac_load  <= 1'b0;
         op_zero   <= 1'b0;
         res_valid <= 1'b0;
         tile_row  <= '0;
         tile_col  <= '0;
      end else begin
         done     <= 1'b0;
         mac_load <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_RUN;
                  busy     <= 1'b1;
                  mac_ce   <= 1'b1;
                  mac_load <= 1'b1;
                  op_zero  <= 1'b0;
                  tile_row <= '0;
                  tile_col <= '0;
                  frow     <= '0;
                  fcol     <= '0;
                  fdep     <= '0;
                  irow     <= '0;
                  icol     <= '0;
                  idep     <= '0;
               end
            end

            S_RUN: begin
               if (frow == K_LAST && fcol == K_LAST && fdep == D_LAST) begin
                  state     <= S_DRAIN;
                  op_zero   <= 1'b1;
                  drain_cnt <= '0;
                  frow      <= '0;
                  fcol      <= '0;
                  fdep      <= '0;
                  idep      <= '0;
                  irow      <= tile_row;
                  icol      <= tile_col;
               end else if (fdep == D_LAST) begin
                  fdep <= '0;
                  idep <= '0;
                  if (fcol == K_LAST) begin
                     fcol <= '0;
                     icol <= tile_col;
                     frow <= frow + ONE;
                     irow <= irow + ONE;
                  end else begin
                     fcol <= fcol + ONE;
                     icol <= icol + ONE;
                  end
               end else begin
                  fdep <= fdep + ONE;
                  idep <= idep + ONE;
               end
            end

            S_DRAIN: begin
               if (drain_cnt == DR_LAST) begin
                  state     <= S_HOLD;
                  mac_ce    <= 1'b0;
                  op_zero   <= 1'b0;
                  res_valid <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 3'd1;
               end
            end

            S_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (tile_row == TR_LAST && tile_col == TC_LAST) begin
                     state    <= S_DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     tile_row <= '0;
                     tile_col <= '0;
                     irow     <= '0;
                     icol     <= '0;
                  end else begin
                     state    <= S_RUN;
                     mac_ce   <= 1'b1;
                     mac_load <= 1'b1;
                     if (tile_col == TC_LAST) begin
                        tile_col <= '0;
                        tile_row <= tile_row + TWO;
                        icol     <= '0;
                        irow     <= tile_row + TWO;
                     end else begin
                        tile_col <= tile_col + TWO;
                        icol     <= tile_col + TWO;
                        irow     <= tile_row;
                     end
                  end
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/conv_tile_sequencer.md
Name: conv_tile_sequencer

Overview:
- Controller for the four-DSP convolution datapath. Each DSP accumulates one pixel of a 2x2 output tile.
- Steps one shared tap index (filter row/col/depth) and the image index for the tile origin through every K x K x DEPTH tap of each tile, then drains the MAC pipeline.
- Presents each finished tile with a valid/ready handshake and walks the tiles in row-major order until the whole output map is done.
- Sits between the top-level start/done control and the MACC array. The datapath adds the per-DSP +0/+1 row/col offsets itself.

Parameters:
- IMG_H, 4, image rows.
- IMG_W, 4, image columns.
- DEPTH, 3, channels in both image and filter.
- K, 3, filter height and width.
- MAC_LAT, 1, MACC latency in cycles (1..4).
- IW, 4, width of every index port. Must satisfy 2^IW > max(IMG_H, IMG_W, DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a full-image pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last tile handshake.
- frow, fcol, fdep  out  IW each  filter tap index.
- irow, icol  out  IW each  image index for DSP0: tile origin + frow/fcol.
- idep  out  IW  image depth index; always equals fdep.
- mac_ce  out  1  MACC clock enable.
- mac_load  out  1  first tap of a tile; MACC loads 0 + product.
- op_zero  out  1  datapath forces the B operand to 0.
- res_valid  out  1  all four accumulators hold the current tile result.
- res_ready  in  1  consumer accepts the tile.
- tile_row, tile_col  out  IW each  origin of the current output tile.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, every output 0, all counters 0. Reset mid-pass abandons the pass with no done pulse.
- Output map size: OH = IMG_H-K+1, OW = IMG_W-K+1. Both must be even; tiles step by 2. Tile count is (OH/2)*(OW/2). Tile order is tile_col fastest, then tile_row.
- Tap order: fdep fastest, then fcol, then frow. NT = K*K*DEPTH taps per tile (27 at defaults).
- IDLE:
  - start=1 -> RUN on the next edge, with tile 0,0 and all tap indices 0.
  - busy=0 and mac_ce=0.
- RUN: one tap per cycle.
  - mac_ce=1 and op_zero=0.
  - mac_load=1 only on tap 0.
  - Indices advance every edge, with depth wrap -> col++ and col wrap -> row++.
  - After tap NT-1: indices return to 0 and state -> DRAIN.
- DRAIN: lasts exactly MAC_LAT cycles.
  - mac_ce=1, op_zero=1, mac_load=0, indices held at 0.
  - Then -> HOLD.
- HOLD:
  - res_valid=1, mac_ce=0, so accumulators are frozen.
  - tile_row/tile_col are stable.
  - On res_ready=1 at an edge: res_valid drops next cycle.
  - If tiles remain: the tile origin advances and state -> RUN (mac_load on its first tap).
  - Otherwise: state -> DONE.
- DONE: lasts one cycle. done=1, busy=0, then -> IDLE.
- busy: 1 in RUN, DRAIN and HOLD.
- start outside IDLE is ignored.
- start in the same cycle as done is ignored. A new pass needs start while in IDLE.
- res_ready outside HOLD is ignored.
- No combinational path from res_ready or start to any output. All outputs are registered.
- Index arithmetic is unsigned IW-bit. irow/icol never exceed IMG_H-2 / IMG_W-2 for DSP0.

Test Plan:
- Defaults, res_ready tied 1, start pulsed at edge 0:
  - RUN occupies cycles 1-27, DRAIN cycle 28, res_valid high cycle 29, done pulse cycle 30.
  - With a 1s image and the 26..0 filter, conv00..conv11 each equal 351.
- Tap-order check, defaults:
  - Tap 0 is (0,0,0) with mac_load=1.
  - Tap 3 is (0,1,0).
  - Tap 9 is (1,0,0).
  - Tap 26 is (2,2,2).
  - mac_load=0 on all taps after 0.
- IMG_H=IMG_W=6:
  - 4 tiles in order (0,0), (0,2), (2,0), (2,2).
  - Tile (0,2) tap 0 drives icol=2.
  - Exactly 4 res_valid handshakes, then one done.
- Backpressure: hold res_ready=0 for 5 cycles in HOLD.
  - res_valid, tile_row and tile_col stay stable.
  - mac_ce stays 0.
  - The next tile starts the cycle after res_ready=1.
- start asserted repeatedly during RUN -> ignored; exactly one done.
- rst pulsed mid-RUN -> all outputs 0 immediately; no done. A new start then runs cleanly.
- MAC_LAT=3 -> DRAIN lasts 3 cycles with op_zero=1, and res_valid is at cycle 31.
